bf_pipe: RTL and testbench

- Parametrised, elastic successor to the single-register stage buffer of the pipelined datapath.
- Implements DEPTH chained stage registers of WIDTH bits, each with a valid bit.
- Uses valid/ready handshaking at both ends: backpressure propagates upstream and empty slots (bubbles) are collapsed.
- Supports synchronous flush (for branch/hazard squash) and reports occupancy; sits between datapath phases wherever a stall-capable stage boundary is needed.

---
 rtl/bf_pipe.sv | 82 ++++++++
 tb/tb_bf_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bf_pipe.sv
// Elastic stage buffer: DEPTH chained valid/data registers with valid/ready at both ends.
// Bubbles collapse toward the output, FLUSH squashes everything, COUNT tracks occupancy.
module bf_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             FLUSH,
  output logic [CW-1:0]    COUNT
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;
  logic [DEPTH:0]   w_rdy;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Stage k may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic acc;
    acc          = OUT_READY;
    w_rdy        = '0;
    w_rdy[DEPTH] = OUT_READY;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc      = ~r_v[k] | acc;
      w_rdy[k] = acc;
    end
  end

  assign IN_READY   = w_rdy[0] & ~FLUSH & ~RST;
  assign OUT_VALID  = r_v[DEPTH-1];
  assign OUT        = r_v[DEPTH-1] ? r_d[DEPTH-1] : '0;
  assign COUNT      = r_count;
  assign w_in_xfer  = IN_VALID & IN_READY;
  assign w_out_xfer = OUT_VALID & OUT_READY & ~FLUSH;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
    end else if (FLUSH) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= IN_VALID;
        if (IN_VALID) r_d[0] <= IN;
      end
      // Data only moves with a valid word; emptied stages keep stale data behind a cleared valid.
      for (int k = 1; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) r_d[k] <= r_d[k-1];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (FLUSH) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_pipe.sv
// Directed and soak bench for bf_pipe with WIDTH=32, DEPTH=3.
module tb_bf_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IN = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] OUT;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic        FLUSH = 1'b0;
  logic [1:0]  COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  bf_pipe #(.WIDTH(32), .DEPTH(3)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FLUSH(FLUSH), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    IN_VALID  = v;
    IN        = d;
    OUT_READY = ordy;
    FLUSH     = fl;
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_word;
  logic        seen;
  logic        sv, sr, sf, exp_ir;

  initial begin
    // reset applied asynchronously before any clock edge
    #1 RST = 1'b1;
    #1;
    chk("rst_out", OUT, 32'h0);
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'h0);
    chk("rst_count", {30'b0, COUNT}, 32'h0);
    chk("rst_in_ready_held", {31'b0, IN_READY}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("rst_release_in_ready", {31'b0, IN_READY}, 32'h1);

    // 1: reset mid-operation
    drive(1, 32'h1, 1, 0); clk_edge();
    drive(1, 32'h2, 1, 0); clk_edge();
    drive(0, 32'h0, 1, 0); clk_edge();
    chk("t1_pre_out", OUT, 32'h1);
    chk("t1_pre_count", {30'b0, COUNT}, 32'h2);
    #2 RST = 1'b1;
    #1;
    chk("t1_async_out", OUT, 32'h0);
    chk("t1_async_out_valid", {31'b0, OUT_VALID}, 32'h0);
    chk("t1_async_count", {30'b0, COUNT}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("t1_in_ready", {31'b0, IN_READY}, 32'h1);
    drive(1, 32'hF, 1, 0); clk_edge();
    drive(0, 32'h0, 1, 0); clk_edge();
    chk("t1_not_yet", {31'b0, OUT_VALID}, 32'h0);
    clk_edge();
    chk("t1_latency_out", OUT, 32'hF);
    chk("t1_latency_valid", {31'b0, OUT_VALID}, 32'h1);
    clk_edge();
    chk("t1_drained", {30'b0, COUNT}, 32'h0);

    // 2: streaming
    drive(1, 32'h1, 1, 0); clk_edge(); chk("t2_count1", {30'b0, COUNT}, 32'd1);
    drive(1, 32'h2, 1, 0); clk_edge(); chk("t2_count2", {30'b0, COUNT}, 32'd2);
    drive(1, 32'hF, 1, 0); clk_edge(); chk("t2_count3", {30'b0, COUNT}, 32'd3);
    chk("t2_out0", OUT, 32'h1);
    drive(0, 32'h0, 1, 0); clk_edge(); chk("t2_count4", {30'b0, COUNT}, 32'd2);
    chk("t2_out1", OUT, 32'h2);
    clk_edge(); chk("t2_count5", {30'b0, COUNT}, 32'd1);
    chk("t2_out2", OUT, 32'hF);
    clk_edge(); chk("t2_count6", {30'b0, COUNT}, 32'd0);
    chk("t2_out_gated", OUT, 32'h0);
    chk("t2_out_valid", {31'b0, OUT_VALID}, 32'h0);

    // 3: backpressure
    drive(1, 32'hF0F0F0F0, 0, 0); clk_edge();
    drive(1, 32'hAAAAAAAA, 0, 0); clk_edge();
    drive(1, 32'h1, 0, 0); clk_edge();
    chk("t3_count_full", {30'b0, COUNT}, 32'd3);
    chk("t3_out_head", OUT, 32'hF0F0F0F0);
    drive(1, 32'h2, 0, 0);
    #1 chk("t3_in_ready_blocked", {31'b0, IN_READY}, 32'h0);
    clk_edge();
    chk("t3_hold_count", {30'b0, COUNT}, 32'd3);
    chk("t3_hold_out", OUT, 32'hF0F0F0F0);
    drive(1, 32'h2, 1, 0);
    #1 chk("t3_in_ready_same_cycle", {31'b0, IN_READY}, 32'h1);
    clk_edge();
    chk("t3_push_pop_count", {30'b0, COUNT}, 32'd3);
    chk("t3_order1", OUT, 32'hAAAAAAAA);
    drive(0, 32'h0, 1, 0); clk_edge();
    chk("t3_order2", OUT, 32'h1);
    clk_edge();
    chk("t3_order3", OUT, 32'h2);
    clk_edge();
    chk("t3_empty", {31'b0, OUT_VALID}, 32'h0);

    // 4: bubble collapse
    drive(1, 32'h1, 0, 0); clk_edge();
    drive(0, 32'h0, 0, 0); clk_edge();
    clk_edge();
    drive(1, 32'h2, 0, 0); clk_edge();
    drive(0, 32'h0, 0, 0); clk_edge();
    chk("t4_count", {30'b0, COUNT}, 32'd2);
    chk("t4_adjacent", {29'b0, dut.r_v}, 32'b110);
    chk("t4_head", OUT, 32'h1);
    drive(0, 32'h0, 1, 0); clk_edge();
    chk("t4_next", OUT, 32'h2);
    chk("t4_next_valid", {31'b0, OUT_VALID}, 32'h1);
    clk_edge();
    chk("t4_empty", {30'b0, COUNT}, 32'd0);

    // 5: flush
    drive(1, 32'hA, 0, 0); clk_edge();
    drive(1, 32'hB, 0, 0); clk_edge();
    drive(1, 32'hC, 0, 0); clk_edge();
    chk("t5_full", {30'b0, COUNT}, 32'd3);
    drive(1, 32'hDEADBEEF, 1, 1);
    #1 chk("t5_in_ready", {31'b0, IN_READY}, 32'h0);
    clk_edge();
    chk("t5_count", {30'b0, COUNT}, 32'd0);
    chk("t5_out_valid", {31'b0, OUT_VALID}, 32'h0);
    chk("t5_out", OUT, 32'h0);
    drive(0, 32'h0, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clk_edge();
      if (OUT_VALID || OUT == 32'hDEADBEEF) seen = 1'b1;
    end
    chk("t5_no_deadbeef", {31'b0, seen}, 32'h0);

    // 6: random soak against a scoreboard queue
    q.delete();
    for (int i = 0; i < 2000; i++) begin
      sv = 1'($urandom_range(1));
      sr = 1'($urandom_range(1));
      sf = ($urandom_range(99) == 0);
      drive(sv, $urandom, sr, sf);
      #1;
      exp_ir = !sf && (q.size() < 3 || sr);
      chk("soak_in_ready", {31'b0, IN_READY}, {31'b0, exp_ir});
      if (!OUT_VALID) chk("soak_out_gated", OUT, 32'h0);
      if (sf) begin
        q.delete();
      end else begin
        if (OUT_VALID && sr) begin
          if (q.size() == 0) chk("soak_underflow", {31'b0, OUT_VALID}, 32'h0);
          else begin
            exp_word = q.pop_front();
            chk("soak_data", OUT, exp_word);
          end
        end
        if (sv && exp_ir) q.push_back(IN);
      end
      clk_edge();
      chk("soak_count", {30'b0, COUNT}, q.size());
      chk("soak_popcount", $countones(dut.r_v), {30'b0, COUNT});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
